result_check: RTL and testbench
===============================

RESULT_CHECK -- requirements
Module: result_check

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 20, memory word address width; DATA_WIDTH, default 16, memory data width; STF_WIDTH, default 24, vector width; CHF_WIDTH, default STF_WIDTH+ADDR_WIDTH, check record width; SCC_WIDTH, default 5, command width; SCD_WIDTH, default 24, command data width; CNT_WIDTH, default 16, counter width; RES_BASE, default 20'h80000, first word of the fail-record region.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clock in 1: sole clock.
- reset in 1: async active-high reset.
- clear in 1: sync pulse; zeroes counters and record pointer.
- cfifo_data in CHF_WIDTH: {expected[STF_WIDTH-1:0], vec_addr[ADDR_WIDTH-1:0]}; show-ahead.
- cfifo_rdempty in 1: check FIFO empty.
- cfifo_rdreq out 1: check FIFO pop.
- rfifo_data in STF_WIDTH: DUT result vector; show-ahead.
- rfifo_rdempty in 1: result FIFO empty.
- rfifo_rdreq out 1: result FIFO pop.
- sc_cmd in SCC_WIDTH: command from stimulus block (00000 idle, 00001 bitmask).
- sc_data in SCD_WIDTH: command payload.
- sc_ready out 1: checker in IDLE.
- mem_address out ADDR_WIDTH: Avalon-MM write address.
- mem_byteenable out DATA_WIDTH/8: constant all ones.
- mem_write out 1: write strobe.
- mem_writedata out DATA_WIDTH: write data.
- mem_waitrequest in 1: slave stall.
- pass_count out CNT_WIDTH: vectors passed.
- fail_count out CNT_WIDTH: vectors failed.
- done out 1: IDLE and both FIFOs empty.

Function
REQ-004 SHALL hold a STF_WIDTH bitmask register; load sc_data[STF_WIDTH-1:0] in any cycle where sc_cmd==00001, in any state; other sc_cmd values ignored.
REQ-005 SHALL implement states IDLE, COMPARE, WRITE.
REQ-006 IDLE: when cfifo_rdempty==0 and rfifo_rdempty==0, latch expected, vec_addr and result, assert cfifo_rdreq and rfifo_rdreq together for exactly that cycle, go COMPARE; otherwise no rdreq.
REQ-007 SHALL never pop only one FIFO; one FIFO empty -> remain IDLE, no pop.
REQ-008 COMPARE (one cycle): mismatch = ((expected XOR result) AND mask) != 0, using the mask value registered before this cycle; a same-cycle load applies to the next vector.
REQ-009 COMPARE, no mismatch: pass_count+1, go IDLE.
REQ-010 COMPARE, mismatch: fail_count+1, go WRITE, word index 0.
REQ-011 Both counters SHALL saturate at all-ones, not wrap.
REQ-012 Fail record, 4 words: w0 = zero-extended vec_addr[19:16]; w1 = vec_addr[15:0]; w2 = zero-extended result[23:16]; w3 = result[15:0].
REQ-013 WRITE: mem_write=1, mem_address = RES_BASE + rec_ptr, mem_writedata = current word.
REQ-014 WRITE: a word is accepted when mem_waitrequest==0; on acceptance, rec_ptr+1 and word index +1.
REQ-015 WRITE: while mem_waitrequest==1, address, data and strobe SHALL hold stable.
REQ-016 After w3 is accepted, SHALL go IDLE; no FIFO pop in COMPARE or WRITE.
REQ-017 rec_ptr is CNT_WIDTH wide and wraps modulo 2^CNT_WIDTH within the region, independent of fail_count saturation.
REQ-018 sc_ready = (state==IDLE); done = IDLE and cfifo_rdempty and rfifo_rdempty; mem_write=0 outside WRITE.
REQ-019 Throughput: passing vector 2 cycles IDLE->IDLE; failing vector 6 cycles with no waitrequest.
REQ-020 clear: zeroes pass_count, fail_count, rec_ptr.
REQ-021 clear: does not change state or mask; a record in flight completes with rec_ptr continuing from 0.
REQ-022 clear coincident with a counter increment: clear wins.

Reset
REQ-023 On reset assertion: state IDLE; mask all ones; pass_count, fail_count, rec_ptr = 0; latched vectors 0; all rdreq and mem_write = 0.
REQ-024 Reset mid-WRITE SHALL abort the record immediately; the partial record is not resumed.
REQ-025 Outputs SHALL be valid from the first clock edge after reset deassertion.

Verification
REQ-026 Bench SHALL cover these scenarios:
- Match: expected=result=24'hA5A5A5, mask FFFFFF -> pass_count=1, no mem_write, back to IDLE in 2 cycles.
- Mismatch: expected 24'h000001, result 24'h000000, vec_addr 20'h12345 -> fail_count=1; writes 0001, 2345, 0000, 0000 at 80000..80003.
- Mask: sc_cmd=00001, sc_data=24'hFFFFFE, then expected 000001 vs result 000000 -> counted as pass.
- Stall: waitrequest=1 for 3 cycles on w1 -> address/data stable; total record 9 cycles.
- One FIFO empty (cfifo non-empty, rfifo empty) -> no pop, stays IDLE, done=0.
- Reset asserted during w2 -> IDLE, counters 0, mem_write=0 the same cycle.
- Saturation: fail_count preset near all-ones -> fail_count stays FFFF while rec_ptr wraps to 0.

Source files
------------

// File: rtl/result_check.sv
// -----------------------------------------------------------------------------
// result_check
//
// Compares the response vectors coming back from a device under test with the
// expected vectors queued by the stimulus side. Each check record pairs an
// expected vector with the word address the vector came from; each result
// record holds what the device actually produced. Both arrive through
// show-ahead FIFOs and are always consumed as a pair.
//
// Only the bits selected by the programmable bitmask take part in the
// comparison. A passing vector bumps pass_count. A failing vector bumps
// fail_count and writes a four-word fail record (address high/low, result
// high/low) into memory through an Avalon-MM write master, starting at
// RES_BASE and advancing one word per accepted write.
//
// Ports
//   clock, reset        sole clock, asynchronous active-high reset
//   clear               synchronous pulse: zero counters and record pointer
//   cfifo_*             check FIFO {expected, vec_addr}, show-ahead, pop
//   rfifo_*             result FIFO (device output vector), show-ahead, pop
//   sc_cmd, sc_data     stimulus command bus (00001 = load bitmask)
//   sc_ready            checker is idle
//   mem_*               Avalon-MM write master for fail records
//   pass_count          number of passing vectors (saturating)
//   fail_count          number of failing vectors (saturating)
//   done                idle and both FIFOs empty
// -----------------------------------------------------------------------------
module result_check #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int STF_WIDTH  = 24,
  parameter int CHF_WIDTH  = STF_WIDTH + ADDR_WIDTH,
  parameter int SCC_WIDTH  = 5,
  parameter int SCD_WIDTH  = 24,
  parameter int CNT_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RES_BASE = 20'h80000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [CHF_WIDTH-1:0]    cfifo_data,
  input  logic                    cfifo_rdempty,
  output logic                    cfifo_rdreq,
  input  logic [STF_WIDTH-1:0]    rfifo_data,
  input  logic                    rfifo_rdempty,
  output logic                    rfifo_rdreq,
  input  logic [SCC_WIDTH-1:0]    sc_cmd,
  input  logic [SCD_WIDTH-1:0]    sc_data,
  output logic                    sc_ready,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH/8-1:0] mem_byteenable,
  output logic                    mem_write,
  output logic [DATA_WIDTH-1:0]   mem_writedata,
  input  logic                    mem_waitrequest,
  output logic [CNT_WIDTH-1:0]    pass_count,
  output logic [CNT_WIDTH-1:0]    fail_count,
  output logic                    done
);

  localparam logic [SCC_WIDTH-1:0] CMD_MASK  = SCC_WIDTH'(1);
  localparam logic [1:0]           LAST_WORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_WRITE   = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
    if (value == {CNT_WIDTH{1'b1}}) begin
      return value;
    end else begin
      return value + CNT_WIDTH'(1);
    end
  endfunction

  // A vector fails when any bit selected by the mask differs.
  function automatic logic is_mismatch(input logic [STF_WIDTH-1:0] expected,
                                       input logic [STF_WIDTH-1:0] result,
                                       input logic [STF_WIDTH-1:0] mask);
    return ((expected ^ result) & mask) != {STF_WIDTH{1'b0}};
  endfunction

  state_t                 state_q,    state_d;
  logic [STF_WIDTH-1:0]   mask_q,     mask_d;
  logic [STF_WIDTH-1:0]   expected_q, expected_d;
  logic [STF_WIDTH-1:0]   result_q,   result_d;
  logic [ADDR_WIDTH-1:0]  vec_addr_q, vec_addr_d;
  logic [CNT_WIDTH-1:0]   pass_q,     pass_d;
  logic [CNT_WIDTH-1:0]   fail_q,     fail_d;
  logic [CNT_WIDTH-1:0]   rec_ptr_q,  rec_ptr_d;
  logic [1:0]             word_q,     word_d;
  logic                   pop_s;
  logic [DATA_WIDTH-1:0]  word_data_s;

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mask_q     <= {STF_WIDTH{1'b1}};
      expected_q <= {STF_WIDTH{1'b0}};
      result_q   <= {STF_WIDTH{1'b0}};
      vec_addr_q <= {ADDR_WIDTH{1'b0}};
      pass_q     <= {CNT_WIDTH{1'b0}};
      fail_q     <= {CNT_WIDTH{1'b0}};
      rec_ptr_q  <= {CNT_WIDTH{1'b0}};
      word_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      expected_q <= expected_d;
      result_q   <= result_d;
      vec_addr_q <= vec_addr_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      rec_ptr_q  <= rec_ptr_d;
      word_q     <= word_d;
    end
  end

  // Next-state logic: pair pop, masked compare, fail-record write sequencing.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    result_d   = result_q;
    vec_addr_d = vec_addr_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    rec_ptr_d  = rec_ptr_q;
    word_d     = word_q;
    pop_s      = 1'b0;

    // The mask loads in any state; COMPARE below uses mask_q, so a load in
    // the compare cycle only affects the following vector.
    if (sc_cmd == CMD_MASK) begin
      mask_d = STF_WIDTH'(sc_data);
    end else begin
      mask_d = mask_q;
    end

    case (state_q)
      ST_IDLE: begin
        // Both FIFOs must hold data; a lone check or result is left in place.
        if (!cfifo_rdempty && !rfifo_rdempty) begin
          expected_d = cfifo_data[ADDR_WIDTH +: STF_WIDTH];
          vec_addr_d = cfifo_data[ADDR_WIDTH-1:0];
          result_d   = rfifo_data;
          pop_s      = 1'b1;
          state_d    = ST_COMPARE;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_COMPARE: begin
        if (is_mismatch(expected_q, result_q, mask_q)) begin
          fail_d  = sat_inc(fail_q);
          word_d  = 2'd0;
          state_d = ST_WRITE;
        end else begin
          pass_d  = sat_inc(pass_q);
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        // Address and data are decoded from registers only, so they stay
        // put for as long as the slave stalls.
        if (!mem_waitrequest) begin
          rec_ptr_d = rec_ptr_q + CNT_WIDTH'(1);
          word_d    = word_q + 2'd1;
          if (word_q == LAST_WORD) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clear overrides any increment in the same cycle; state and mask are
    // untouched so a record in flight carries on from pointer zero.
    if (clear) begin
      pass_d    = {CNT_WIDTH{1'b0}};
      fail_d    = {CNT_WIDTH{1'b0}};
      rec_ptr_d = {CNT_WIDTH{1'b0}};
    end else begin
      pass_d    = pass_d;
    end
  end

  // Fail-record word select: address high, address low, result high, result low.
  always_comb begin
    case (word_q)
      2'd0:    word_data_s = DATA_WIDTH'(vec_addr_q >> DATA_WIDTH);
      2'd1:    word_data_s = DATA_WIDTH'(vec_addr_q);
      2'd2:    word_data_s = DATA_WIDTH'(result_q >> DATA_WIDTH);
      2'd3:    word_data_s = DATA_WIDTH'(result_q);
      default: word_data_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Pops are gated with reset so nothing is consumed while held in reset.
  assign cfifo_rdreq    = pop_s && !reset;
  assign rfifo_rdreq    = pop_s && !reset;

  assign sc_ready       = (state_q == ST_IDLE);
  assign done           = (state_q == ST_IDLE) && cfifo_rdempty && rfifo_rdempty;

  assign mem_write      = (state_q == ST_WRITE);
  assign mem_address    = RES_BASE + ADDR_WIDTH'(rec_ptr_q);
  assign mem_writedata  = word_data_s;
  assign mem_byteenable = {(DATA_WIDTH/8){1'b1}};

  assign pass_count     = pass_q;
  assign fail_count     = fail_q;

endmodule

// File: tb/tb_result_check.sv
// -----------------------------------------------------------------------------
// tb_result_check
//
// Scoreboard bench for result_check. Stimulus pushes vectors into two small
// queue-based FIFO models and, at the same moment, pushes the expected fail
// record words and the expected IDLE-to-IDLE cycle count into scoreboard
// queues. A monitor running on the falling edge pops and compares whenever
// the DUT completes a memory write or returns to IDLE. The counters use a
// narrow CNT_WIDTH so saturation and pointer wrap are reachable quickly.
// -----------------------------------------------------------------------------
module tb_result_check;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int SW = 24;
  localparam int CW = 8;
  localparam logic [AW-1:0] BASE = 20'h80000;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic [SW+AW-1:0]  cfifo_data = '0;
  logic              cfifo_rdempty = 1'b1;
  logic              cfifo_rdreq;
  logic [SW-1:0]     rfifo_data = '0;
  logic              rfifo_rdempty = 1'b1;
  logic              rfifo_rdreq;
  logic [4:0]        sc_cmd = 5'b00000;
  logic [23:0]       sc_data = 24'h000000;
  logic              sc_ready;
  logic [AW-1:0]     mem_address;
  logic [DW/8-1:0]   mem_byteenable;
  logic              mem_write;
  logic [DW-1:0]     mem_writedata;
  logic              mem_waitrequest = 1'b0;
  logic [CW-1:0]     pass_count;
  logic [CW-1:0]     fail_count;
  logic              done;

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO models and scoreboard queues
  logic [SW+AW-1:0] cq[$];
  logic [SW-1:0]    rq[$];
  wr_t              exp_wr_q[$];
  int               lat_q[$];

  // Reference model state
  logic [SW-1:0] m_mask = 24'hFFFFFF;
  logic [CW-1:0] m_pass = '0;
  logic [CW-1:0] m_fail = '0;
  logic [CW-1:0] m_ptr  = '0;

  // Stall control owned by stimulus
  logic [AW-1:0] stall_addr = '0;
  int            stall_len  = 0;

  always #5 clock = ~clock;

  result_check #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STF_WIDTH(SW), .CNT_WIDTH(CW),
    .RES_BASE(BASE)
  ) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .cfifo_data(cfifo_data), .cfifo_rdempty(cfifo_rdempty), .cfifo_rdreq(cfifo_rdreq),
    .rfifo_data(rfifo_data), .rfifo_rdempty(rfifo_rdempty), .rfifo_rdreq(rfifo_rdreq),
    .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_ready(sc_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
    .pass_count(pass_count), .fail_count(fail_count), .done(done)
  );

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_wr(input logic [DW-1:0] d);
    wr_t w;
    w.addr = BASE + AW'(m_ptr);
    w.data = d;
    exp_wr_q.push_back(w);
    m_ptr = m_ptr + 8'd1;
  endtask

  // Queue one vector and its expected outcome; extra = stall cycles expected.
  task automatic push_vec(input logic [SW-1:0] e, input logic [AW-1:0] a,
                          input logic [SW-1:0] r, input int extra);
    if (((e ^ r) & m_mask) != 24'h000000) begin
      if (m_fail != 8'hFF) m_fail = m_fail + 8'd1;
      lat_q.push_back(6 + extra);
      push_wr(DW'(a >> 16));
      push_wr(a[15:0]);
      push_wr(DW'(r >> 16));
      push_wr(r[15:0]);
    end else begin
      if (m_pass != 8'hFF) m_pass = m_pass + 8'd1;
      lat_q.push_back(2);
    end
    cq.push_back({e, a});
    rq.push_back(r);
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("drain_within_budget", {63'd0, ok}, 64'd1);
  endtask

  // FIFO model: pop after the edge on which the DUT asserted rdreq, then
  // present the new head (show-ahead).
  initial begin
    bit pend;
    pend = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      if (pend) begin
        if (cq.size() != 0) void'(cq.pop_front());
        if (rq.size() != 0) void'(rq.pop_front());
      end
      cfifo_rdempty = (cq.size() == 0);
      rfifo_rdempty = (rq.size() == 0);
      cfifo_data    = (cq.size() != 0) ? cq[0] : '0;
      rfifo_data    = (rq.size() != 0) ? rq[0] : '0;
      @(negedge clock);
      pend = cfifo_rdreq;
    end
  end

  // Monitor: slave stall generation, write scoreboard, hold stability, latency.
  initial begin
    bit            lat_active;
    int            lat_cnt;
    bit            hold_prev;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    int            stall_run;
    bit            wr_new;
    wr_t           w;
    lat_active = 1'b0; lat_cnt = 0; hold_prev = 1'b0; stall_run = 0;
    prev_addr = '0; prev_data = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        lat_active = 1'b0;
        hold_prev  = 1'b0;
        stall_run  = 0;
        mem_waitrequest = 1'b0;
      end else begin
        if (cfifo_rdreq || rfifo_rdreq)
          check_eq("rdreq_paired", {63'd0, cfifo_rdreq}, {63'd0, rfifo_rdreq});
        if (lat_active) begin
          if (sc_ready) begin
            if (lat_q.size() == 0) begin
              check_eq("unexpected_vector", 64'd1, 64'd0);
            end else begin
              check_eq("idle_to_idle_cycles", 64'(lat_cnt), 64'(lat_q.pop_front()));
            end
            lat_active = 1'b0;
          end else begin
            lat_cnt++;
          end
        end
        if (cfifo_rdreq) begin
          lat_active = 1'b1;
          lat_cnt    = 1;
        end
        if (hold_prev)
          check_eq("stall_hold", {mem_write, mem_address, mem_writedata},
                   {1'b1, prev_addr, prev_data});
        wr_new = 1'b0;
        if (mem_write && mem_address == stall_addr && stall_run < stall_len) begin
          wr_new = 1'b1;
          stall_run++;
        end
        mem_waitrequest = wr_new;
        if (mem_write && !wr_new) begin
          stall_run = 0;
          if (exp_wr_q.size() == 0) begin
            check_eq("unexpected_write", {44'd0, mem_address}, 64'd0);
          end else begin
            w = exp_wr_q.pop_front();
            check_eq("write_addr", 64'(mem_address), 64'(w.addr));
            check_eq("write_data", 64'(mem_writedata), 64'(w.data));
          end
        end
        hold_prev = mem_write && wr_new;
        prev_addr = mem_address;
        prev_data = mem_writedata;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the end of the sequence");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    logic [AW-1:0] tgt;
    bit            found;

    // Reset held with a matching vector already waiting
    push_vec(24'hA5A5A5, 20'h00010, 24'hA5A5A5, 0);
    repeat (3) tick();
    check_eq("rst_pass_count", 64'(pass_count), 64'd0);
    check_eq("rst_fail_count", 64'(fail_count), 64'd0);
    check_eq("rst_mem_write", {63'd0, mem_write}, 64'd0);
    check_eq("rst_rdreq", {62'd0, cfifo_rdreq, rfifo_rdreq}, 64'd0);
    check_eq("rst_sc_ready", {63'd0, sc_ready}, 64'd1);
    check_eq("rst_done_fifo_busy", {63'd0, done}, 64'd0);
    check_eq("byteenable", 64'(mem_byteenable), 64'h3);
    reset = 1'b0;

    // Match
    wait_done(20);
    check_eq("match_pass_count", 64'(pass_count), 64'd1);
    check_eq("match_fail_count", 64'(fail_count), 64'd0);

    // Mismatch: record 0001 2345 0000 0000 at 80000..80003
    push_vec(24'h000001, 20'h12345, 24'h000000, 0);
    wait_done(30);
    check_eq("mismatch_fail_count", 64'(fail_count), 64'd1);
    check_eq("mismatch_pass_count", 64'(pass_count), 64'd1);

    // Mask out bit 0
    sc_cmd = 5'b00001; sc_data = 24'hFFFFFE; m_mask = 24'hFFFFFE;
    tick();
    sc_cmd = 5'b00010; sc_data = 24'h000000;
    tick();
    sc_cmd = 5'b00000;
    push_vec(24'h000001, 20'h00020, 24'h000000, 0);
    wait_done(20);
    check_eq("mask_pass_count", 64'(pass_count), 64'd2);
    push_vec(24'h000003, 20'h00030, 24'h000001, 0);
    wait_done(30);
    check_eq("mask_fail_count", 64'(fail_count), 64'd2);
    sc_cmd = 5'b00001; sc_data = 24'hFFFFFF; m_mask = 24'hFFFFFF;
    tick();
    sc_cmd = 5'b00000;

    // Stall three cycles on w1
    stall_addr = BASE + AW'(m_ptr) + 20'd1;
    stall_len  = 3;
    push_vec(24'hABCDEF, 20'hFEDCB, 24'h123456, 3);
    wait_done(40);
    stall_len  = 0;
    check_eq("stall_fail_count", 64'(fail_count), 64'd3);

    // Back-to-back pass / fail / pass
    push_vec(24'h5A5A5A, 20'h00100, 24'h5A5A5A, 0);
    push_vec(24'h800000, 20'h00200, 24'h000000, 0);
    push_vec(24'h0F0F0F, 20'h00300, 24'h0F0F0F, 0);
    wait_done(40);
    check_eq("b2b_pass_count", 64'(pass_count), 64'd4);
    check_eq("b2b_fail_count", 64'(fail_count), 64'd4);

    // Only the check FIFO holds data
    cq.push_back({24'h000001, 20'h00001});
    repeat (4) begin
      tick();
      check_eq("one_empty_no_pop", {62'd0, cfifo_rdreq, rfifo_rdreq}, 64'd0);
    end
    check_eq("one_empty_sc_ready", {63'd0, sc_ready}, 64'd1);
    check_eq("one_empty_done", {63'd0, done}, 64'd0);
    cq.delete();
    tick(); tick();
    check_eq("one_empty_done_after", {63'd0, done}, 64'd1);

    // Clear while idle
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_pass = '0; m_fail = '0; m_ptr = '0;
    check_eq("clear_pass_count", 64'(pass_count), 64'd0);
    check_eq("clear_fail_count", 64'(fail_count), 64'd0);
    push_vec(24'h000000, 20'h0ABCD, 24'hFF00FF, 0);
    wait_done(30);
    check_eq("post_clear_fail_count", 64'(fail_count), 64'd1);

    // Reset during w2
    tgt   = BASE + AW'(m_ptr) + 20'd2;
    found = 1'b0;
    push_vec(24'h000010, 20'h00077, 24'h000000, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_write && mem_address == tgt) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("reached_w2", {63'd0, found}, 64'd1);
    reset = 1'b1;
    #1;
    check_eq("abort_mem_write", {63'd0, mem_write}, 64'd0);
    check_eq("abort_sc_ready", {63'd0, sc_ready}, 64'd1);
    check_eq("abort_fail_count", 64'(fail_count), 64'd0);
    check_eq("abort_pass_count", 64'(pass_count), 64'd0);
    repeat (2) tick();
    exp_wr_q.delete();
    lat_q.delete();
    m_pass = '0; m_fail = '0; m_ptr = '0; m_mask = 24'hFFFFFF;
    reset = 1'b0;
    push_vec(24'h000002, 20'h00088, 24'h000000, 0);
    wait_done(30);
    check_eq("after_abort_fail_count", 64'(fail_count), 64'd1);

    // Saturation: fail_count sticks at all-ones while rec_ptr wraps
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_pass = '0; m_fail = '0; m_ptr = '0;
    for (int i = 0; i < 256; i++) push_vec(24'h000001, AW'(i), 24'h000000, 0);
    wait_done(256 * 6 + 100);
    check_eq("sat_fail_count", 64'(fail_count), 64'hFF);
    check_eq("sat_pass_count", 64'(pass_count), 64'd0);
    push_vec(24'h000001, 20'h0BEEF, 24'h000000, 0);
    wait_done(30);
    check_eq("sat_fail_count_hold", 64'(fail_count), 64'hFF);

    repeat (3) tick();
    check_eq("writes_drained", 64'(exp_wr_q.size()), 64'd0);
    check_eq("vectors_drained", 64'(lat_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
